// File: rtl/ysyx_25020047_lsu_bus.sv
// ysyx_25020047_lsu_bus: sequential load/store unit that checks alignment, steers byte lanes,
// extends loads and drives a valid/ready data bus with a bounded-latency timeout.
module ysyx_25020047_lsu_bus #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rsp_err
);
    localparam int NB = DATA_W / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t             state, state_n;
    logic               ready, we_q, uns_q;
    logic [1:0]         size_q, err;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q, rdata, shifted, mask, top, ext;
    logic [31:0]        cnt;
    logic [OB-1:0]      off;
    logic               accept, misaligned, timed_out;

    assign off        = addr_q[OB-1:0];
    assign accept     = ready && req_valid;
    assign misaligned = ((req_addr[2:0] & ((3'd1 << req_size) - 3'd1)) != 3'd0)
                        || (req_size == 2'd3 && DATA_W == 32);
    assign timed_out  = (TIMEOUT != 0) && (cnt + 32'd1 >= 32'(TIMEOUT));

    // mask keeps the low 8*2^size bits; top isolates the sign bit of that field
    assign shifted = mem_rdata >> {off, 3'b000};
    assign mask    = ~({DATA_W{1'b1}} << (7'd8 << size_q));
    assign top     = mask & ~(mask >> 1);
    assign ext     = (shifted & mask) | ((!uns_q && |(shifted & top)) ? ~mask : '0);

    assign req_ready     = ready;
    assign rsp_valid     = state == RESP;
    assign rsp_rdata     = rdata;
    assign rsp_err       = err;
    assign mem_req_valid = state == REQ;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q & ~ADDR_W'(NB - 1);
    assign mem_wdata     = wdata_q << {off, 3'b000};
    assign mem_wstrb     = we_q ? ~({NB{1'b1}} << (4'd1 << size_q)) << off : '0;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: state_n = accept ? (misaligned ? RESP : REQ) : IDLE;
            REQ:  state_n = mem_req_ready ? WAIT : (timed_out ? RESP : REQ);
            WAIT: state_n = (mem_rsp_valid || timed_out) ? RESP : WAIT;
            RESP: state_n = rsp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            err     <= 2'b00;
            rdata   <= '0;
        end else begin
            state <= state_n;
            ready <= state_n == IDLE;
            cnt   <= (state == REQ || state == WAIT) ? cnt + 32'd1 : '0;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err     <= misaligned ? 2'b01 : 2'b00;
                rdata   <= '0;
            end
            if (state == WAIT && mem_rsp_valid) begin
                err   <= mem_rsp_err ? 2'b10 : 2'b00;
                rdata <= (we_q || mem_rsp_err) ? '0 : ext;
            end else if ((state == REQ || state == WAIT) && state_n == RESP) begin
                err <= 2'b11;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25020047_lsu_bus.sv
// tb_ysyx_25020047_lsu_bus: drives a 32-bit (TIMEOUT=4) and a 64-bit (no timeout) LSU
// through shared stimulus and checks them against an arithmetic reference model.
module tb_ysyx_25020047_lsu_bus;
    localparam int T32 = 4;

    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0;
    logic [63:0] req_wdata = 64'h0, mem_rdata = 64'h0;
    logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;

    logic        r32_req_ready, r32_rsp_valid, r32_mem_req_valid, r32_mem_we;
    logic [1:0]  r32_rsp_err;
    logic [31:0] r32_rsp_rdata, r32_mem_addr, r32_mem_wdata;
    logic [3:0]  r32_mem_wstrb;
    logic        r64_req_ready, r64_rsp_valid, r64_mem_req_valid, r64_mem_we;
    logic [1:0]  r64_rsp_err;
    logic [63:0] r64_rsp_rdata, r64_mem_wdata;
    logic [31:0] r64_mem_addr;
    logic [7:0]  r64_mem_wstrb;

    logic        req_ready, rsp_valid, mem_req_valid, mem_we;
    logic [1:0]  rsp_err;
    logic [63:0] rsp_rdata, mem_wdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wstrb;

    int checks = 0, failures = 0;
    logic [31:0] last_addr;
    logic [63:0] last_wdata, last_rdata;
    logic [7:0]  last_strb;
    logic [1:0]  last_err;

    always #5 clk = ~clk;

    ysyx_25020047_lsu_bus #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(T32)) dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(r32_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .rsp_valid(r32_rsp_valid), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(r32_rsp_rdata), .rsp_err(r32_rsp_err), .mem_req_valid(r32_mem_req_valid),
        .mem_req_ready(mem_req_ready & ~sel), .mem_we(r32_mem_we), .mem_addr(r32_mem_addr),
        .mem_wdata(r32_mem_wdata), .mem_wstrb(r32_mem_wstrb), .mem_rsp_valid(mem_rsp_valid & ~sel),
        .mem_rdata(mem_rdata[31:0]), .mem_rsp_err(mem_rsp_err)
    );

    ysyx_25020047_lsu_bus #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(0)) dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(r64_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(r64_rsp_valid), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(r64_rsp_rdata), .rsp_err(r64_rsp_err), .mem_req_valid(r64_mem_req_valid),
        .mem_req_ready(mem_req_ready & sel), .mem_we(r64_mem_we), .mem_addr(r64_mem_addr),
        .mem_wdata(r64_mem_wdata), .mem_wstrb(r64_mem_wstrb), .mem_rsp_valid(mem_rsp_valid & sel),
        .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err)
    );

    assign req_ready     = sel ? r64_req_ready : r32_req_ready;
    assign rsp_valid     = sel ? r64_rsp_valid : r32_rsp_valid;
    assign rsp_err       = sel ? r64_rsp_err : r32_rsp_err;
    assign rsp_rdata     = sel ? r64_rsp_rdata : {32'h0, r32_rsp_rdata};
    assign mem_req_valid = sel ? r64_mem_req_valid : r32_mem_req_valid;
    assign mem_we        = sel ? r64_mem_we : r32_mem_we;
    assign mem_addr      = sel ? r64_mem_addr : r32_mem_addr;
    assign mem_wdata     = sel ? r64_mem_wdata : {32'h0, r32_mem_wdata};
    assign mem_wstrb     = sel ? r64_mem_wstrb : {4'h0, r32_mem_wstrb};

    // Reference: byte offset within the beat, shifted store data/strobes, extended load value
    function automatic void model(input bit s64, input logic we, input logic [1:0] size,
                                  input logic uns, input logic [31:0] addr,
                                  input logic [63:0] wdata, input logic [63:0] rdata,
                                  output bit mis, output logic [31:0] ea, output logic [63:0] ew,
                                  output logic [7:0] es, output logic [63:0] eld);
        int nb, off, bytes;
        logic [127:0] t, m;
        nb    = s64 ? 8 : 4;
        off   = int'(addr[2:0]) % nb;
        bytes = 1 << size;
        mis   = (off % bytes) != 0 || (size == 2'd3 && !s64);
        ea    = addr - 32'(off);
        t     = {64'h0, wdata} << (8 * off);
        ew    = s64 ? t[63:0] : {32'h0, t[31:0]};
        es    = we ? 8'(((1 << bytes) - 1) << off) : 8'h0;
        m     = (128'd1 << (8 * bytes)) - 128'd1;
        t     = (({64'h0, rdata} & (s64 ? {128{1'b1}} : 128'hFFFF_FFFF)) >> (8 * off)) & m;
        if (!uns && ((t >> (8 * bytes - 1)) & 128'd1) != 128'd0) t = t | ~m;
        eld   = we ? 64'h0 : (s64 ? t[63:0] : {32'h0, t[31:0]});
    endfunction

    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                         input int req_delay, input int rsp_delay, input logic berr, input int hold);
        bit mis, to;
        logic [31:0] ea;
        logic [63:0] ew, eld, erd;
        logic [7:0]  es;
        logic [1:0]  eerr;
        int tmo, k_done, last;
        model(sel, we, size, uns, addr, wdata, rdata, mis, ea, ew, es, eld);
        tmo    = sel ? 0 : T32;
        k_done = req_delay + 1 + rsp_delay;
        to     = tmo > 0 && k_done > tmo - 1;
        last   = to ? tmo - 1 : k_done;
        eerr   = mis ? 2'b01 : to ? 2'b11 : berr ? 2'b10 : 2'b00;
        erd    = (mis || to || berr || we) ? 64'h0 : eld;
        last_addr = 32'h0; last_wdata = 64'h0; last_strb = 8'h0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL ready_wait got=%b exp=1", req_ready);
            return;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; mem_rdata = rdata; mem_rsp_err = berr;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = {$urandom, $urandom};
        req_we = ~we; req_size = ~size;
        for (int i = 0; !mis && i <= last; i++) begin
            checks++;
            if (i <= req_delay) begin
                last_addr = mem_addr; last_wdata = mem_wdata; last_strb = mem_wstrb;
                if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp_valid} !==
                    {1'b1, we, ea, ew, es, 1'b0}) begin
                    failures++;
                    $display("FAIL bus_req i=%0d got=%b/%b/%h/%h/%h/%b exp=1/%b/%h/%h/%h/0", i,
                             mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, rsp_valid,
                             we, ea, ew, es);
                end
            end else if ({mem_req_valid, rsp_valid} !== 2'b00) begin
                failures++;
                $display("FAIL bus_wait i=%0d got=%b/%b exp=0/0", i, mem_req_valid, rsp_valid);
            end
            mem_req_ready = i == req_delay;
            mem_rsp_valid = (i == k_done) || (i <= req_delay && $urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            checks++;
            last_rdata = rsp_rdata; last_err = rsp_err;
            if ({rsp_valid, rsp_err, rsp_rdata, req_ready, mem_req_valid} !==
                {1'b1, eerr, erd, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL resp h=%0d got=%b/%b/%h/%b/%b exp=1/%b/%h/0/0", h,
                         rsp_valid, rsp_err, rsp_rdata, req_ready, mem_req_valid, eerr, erd);
            end
            rsp_ready = h == hold;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL resp_done got=%b/%b exp=0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({r32_req_ready, r32_rsp_valid, r32_mem_req_valid, r32_mem_we, r32_mem_wstrb, r32_rsp_err,
             r32_rsp_rdata, r32_mem_addr, r32_mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset32 got=%b%b%b%b %h %b %h %h %h exp=all zero", r32_req_ready,
                     r32_rsp_valid, r32_mem_req_valid, r32_mem_we, r32_mem_wstrb, r32_rsp_err,
                     r32_rsp_rdata, r32_mem_addr, r32_mem_wdata);
        end
        checks++;
        if ({r64_req_ready, r64_rsp_valid, r64_mem_req_valid, r64_mem_we, r64_mem_wstrb, r64_rsp_err,
             r64_rsp_rdata, r64_mem_addr, r64_mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset64 got=%b%b%b%b %h %b %h %h %h exp=all zero", r64_req_ready,
                     r64_rsp_valid, r64_mem_req_valid, r64_mem_we, r64_mem_wstrb, r64_rsp_err,
                     r64_rsp_rdata, r64_mem_addr, r64_mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({r32_req_ready, r64_req_ready} !== 2'b11) begin
            failures++;
            $display("FAIL ready_after_reset got=%b%b exp=11", r32_req_ready, r64_req_ready);
        end
    endtask

    typedef struct {
        bit s64; logic we; logic [1:0] size; logic uns; logic [31:0] addr;
        logic [63:0] wdata, rdata; logic [1:0] err; logic [63:0] rd; logic [31:0] ea;
        logic [63:0] wd; logic [7:0] strb;
    } vec_t;

    task automatic test_directed();
        vec_t vt[14] = '{
            '{1'b0, 1'b0, 2'd2, 1'b0, 32'h80000004, 64'h0, 64'hDEADBEEF, 2'd0, 64'hDEADBEEF, 32'h80000004, 64'h0, 8'h0},
            '{1'b0, 1'b0, 2'd0, 1'b0, 32'h80000003, 64'h0, 64'h80112233, 2'd0, 64'hFFFFFF80, 32'h80000000, 64'h0, 8'h0},
            '{1'b0, 1'b0, 2'd0, 1'b1, 32'h80000003, 64'h0, 64'h80112233, 2'd0, 64'h00000080, 32'h80000000, 64'h0, 8'h0},
            '{1'b0, 1'b0, 2'd1, 1'b1, 32'h80000002, 64'h0, 64'h80112233, 2'd0, 64'h00008011, 32'h80000000, 64'h0, 8'h0},
            '{1'b0, 1'b1, 2'd1, 1'b0, 32'h80000002, 64'hABCD, 64'h0, 2'd0, 64'h0, 32'h80000000, 64'hABCD0000, 8'hC},
            '{1'b0, 1'b1, 2'd0, 1'b0, 32'h80000001, 64'h5A, 64'h0, 2'd0, 64'h0, 32'h80000000, 64'h00005A00, 8'h2},
            '{1'b0, 1'b0, 2'd2, 1'b0, 32'h80000002, 64'h0, 64'hDEADBEEF, 2'd1, 64'h0, 32'h0, 64'h0, 8'h0},
            '{1'b0, 1'b0, 2'd3, 1'b0, 32'h80000008, 64'h0, 64'h12345678, 2'd1, 64'h0, 32'h0, 64'h0, 8'h0},
            '{1'b1, 1'b0, 2'd2, 1'b0, 32'h8000000C, 64'h0, 64'hFFFFFFFF00000000, 2'd0, 64'hFFFFFFFFFFFFFFFF, 32'h80000008, 64'h0, 8'h0},
            '{1'b1, 1'b0, 2'd3, 1'b0, 32'h80000008, 64'h0, 64'h0123456789ABCDEF, 2'd0, 64'h0123456789ABCDEF, 32'h80000008, 64'h0, 8'h0},
            '{1'b1, 1'b0, 2'd2, 1'b1, 32'h8000000C, 64'h0, 64'hFFFFFFFF00000000, 2'd0, 64'h00000000FFFFFFFF, 32'h80000008, 64'h0, 8'h0},
            '{1'b1, 1'b1, 2'd1, 1'b0, 32'h80000006, 64'h1234, 64'h0, 2'd0, 64'h0, 32'h80000000, 64'h1234000000000000, 8'hC0},
            '{1'b1, 1'b1, 2'd3, 1'b0, 32'h80000000, 64'h0123456789ABCDEF, 64'h0, 2'd0, 64'h0, 32'h80000000, 64'h0123456789ABCDEF, 8'hFF},
            '{1'b1, 1'b0, 2'd3, 1'b0, 32'h80000004, 64'h0, 64'h55, 2'd1, 64'h0, 32'h0, 64'h0, 8'h0}
        };
        foreach (vt[n]) begin
            sel = vt[n].s64;
            do_op(vt[n].we, vt[n].size, vt[n].uns, vt[n].addr, vt[n].wdata, vt[n].rdata, 0, 0, 1'b0, 0);
            checks++;
            if ({last_err, last_rdata} !== {vt[n].err, vt[n].rd}) begin
                failures++;
                $display("FAIL directed_rsp[%0d] got=%b/%h exp=%b/%h", n, last_err, last_rdata,
                         vt[n].err, vt[n].rd);
            end
            if (vt[n].err == 2'd0) begin
                checks++;
                if ({last_addr, last_wdata, last_strb} !== {vt[n].ea, vt[n].wd, vt[n].strb}) begin
                    failures++;
                    $display("FAIL directed_bus[%0d] got=%h/%h/%h exp=%h/%h/%h", n, last_addr,
                             last_wdata, last_strb, vt[n].ea, vt[n].wd, vt[n].strb);
                end
            end
        end
    endtask

    task automatic test_errors();
        sel = 1'b0;
        do_op(1'b0, 2'd2, 1'b0, 32'h80000010, 64'h0, 64'hCAFEF00D, 100, 0, 1'b0, 0);
        checks++;
        if ({last_err, last_rdata} !== {2'b11, 64'h0}) begin
            failures++;
            $display("FAIL timeout_req got=%b/%h exp=11/0", last_err, last_rdata);
        end
        do_op(1'b1, 2'd2, 1'b0, 32'h80000010, 64'h11223344, 64'h0, 0, 100, 1'b0, 0);
        checks++;
        if (last_err !== 2'b11) begin
            failures++;
            $display("FAIL timeout_wait got=%b exp=11", last_err);
        end
        do_op(1'b0, 2'd2, 1'b0, 32'h80000010, 64'h0, 64'hCAFEF00D, 0, 1, 1'b1, 0);
        checks++;
        if ({last_err, last_rdata} !== {2'b10, 64'h0}) begin
            failures++;
            $display("FAIL bus_error got=%b/%h exp=10/0", last_err, last_rdata);
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        do_op(1'b0, 2'd1, 1'b0, 32'h80000006, 64'h0, 64'h9ABC0000, 0, 0, 1'b0, 5);
        sel = 1'b1;
        do_op(1'b0, 2'd0, 1'b0, 32'h80000007, 64'h0, 64'hF000000000000000, 2, 3, 1'b0, 5);
    endtask

    task automatic test_reset_mid_op();
        sel = 1'b0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h80000004;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, mem_req_valid, rsp_valid, mem_wstrb, mem_addr, rsp_err} !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%b/%b/%b/%h/%h/%b exp=all zero", req_ready,
                     mem_req_valid, rsp_valid, mem_wstrb, mem_addr, rsp_err);
        end
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'hDEADBEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rsp_valid, mem_req_valid, req_ready} !== 3'b001) begin
                failures++;
                $display("FAIL late_rsp i=%0d got=%b/%b/%b exp=0/0/1", i, rsp_valid,
                         mem_req_valid, req_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int rq, rs;
        for (int n = 0; n < 300; n++) begin
            sel = 1'($urandom_range(0, 1));
            rq  = sel ? $urandom_range(0, 3) : $urandom_range(0, 1);
            rs  = sel ? $urandom_range(0, 3) : (rq == 0 ? $urandom_range(0, 1) : 0);
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'h80000000 | 32'($urandom_range(0, 15)), {$urandom, $urandom},
                  {$urandom, $urandom}, rq, rs, $urandom_range(0, 7) == 0, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
